pipe_hazard_ctrl: RTL and testbench

Central sequencing controller for the 3-stage RV32I pipeline (IF -> DE/EX -> MW, where MW is memory plus writeback). It decodes the instruction in DE against a tracked copy of the instruction in MW and drives the pipeline-control signals:
- stalls, flushes and bubbles;
- the PC source select;
- the forwarding selects.

It also sequences data-memory wait states with a timeout, external-interrupt entry and mret return. It sits beside the immediate/decode logic and the PC mux.

---
 rtl/rv_pkg.sv | 34 +++
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/de_reg_use_decode.sv | 50 +++++
 rtl/pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I opcodes, pc select and controller state types
// Purpose: constants and enums shared by the hazard controller, its decoder
//          and its bus interface.
// Ports:   none (package).
package rv_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_CSR   = 7'b1110011;

  localparam logic [2:0]  F3_PRIV  = 3'b000;
  localparam logic [11:0] MRET_IMM = 12'h302;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_MTVEC  = 2'b10,
    PC_MEPC   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    MEM_WAIT  = 2'b01,
    TRAP_HOLD = 2'b10
  } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
// Purpose: groups the DE/MW status inputs and pipeline-control outputs.
// Ports:   master = pipeline side (drives instr_de, valid_de, br_taken,
//          mem_ready, ext_irq, irq_en; receives controls);
//          slave  = controller side (the reverse).
interface pipe_hazard_ctrl_if;
  import rv_pkg::*;

  logic [31:0] instr_de;
  logic        valid_de;
  logic        br_taken;
  logic        mem_ready;
  logic        ext_irq;
  logic        irq_en;

  logic        stall_if;
  logic        stall_mw;
  logic        flush_de;
  logic        bubble_mw;
  pc_sel_e     pc_sel;
  logic        fwd_a;
  logic        fwd_b;
  logic        epc_we;
  logic        irq_ack;
  logic        mem_fault;
  logic        busy;

  modport master (
    output instr_de, valid_de, br_taken, mem_ready, ext_irq, irq_en,
    input  stall_if, stall_mw, flush_de, bubble_mw, pc_sel, fwd_a, fwd_b,
           epc_we, irq_ack, mem_fault, busy
  );

  modport slave (
    input  instr_de, valid_de, br_taken, mem_ready, ext_irq, irq_en,
    output stall_if, stall_mw, flush_de, bubble_mw, pc_sel, fwd_a, fwd_b,
           epc_we, irq_ack, mem_fault, busy
  );

endinterface

// File: rtl/de_reg_use_decode.sv
// rtl/de_reg_use_decode.sv - register-use and class decode of one instruction
// Purpose: combinational decode of which registers an instruction reads and
//          writes, plus load/store/control/mret classification.
// Ports:   instr (in 32); rs1/rs2/rd fields (out 5 each); uses_rs1, uses_rs2,
//          writes_rd, is_load, is_store, is_ctrl (JAL/JALR/B), is_branch (B),
//          is_mret (out 1 each).
module de_reg_use_decode
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        writes_rd,
  output logic        is_load,
  output logic        is_store,
  output logic        is_ctrl,
  output logic        is_branch,
  output logic        is_mret
);

  logic [6:0] opcode;
  logic [2:0] func3;

  assign opcode = instr[6:0];
  assign func3  = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // CSR immediate forms (func3[2]=1) carry a uimm in the rs1 field.
  assign uses_rs1 = (opcode == OP_R) | (opcode == OP_I) | (opcode == OP_S) |
                    (opcode == OP_B) | (opcode == OP_LOAD) | (opcode == OP_JALR) |
                    ((opcode == OP_CSR) & ~func3[2]);

  assign uses_rs2 = (opcode == OP_R) | (opcode == OP_S) | (opcode == OP_B);

  assign writes_rd = ((opcode == OP_R) | (opcode == OP_I) | (opcode == OP_LOAD) |
                      (opcode == OP_LUI) | (opcode == OP_AUIPC) | (opcode == OP_JAL) |
                      (opcode == OP_JALR) | (opcode == OP_CSR)) & (rd != 5'd0);

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_S);
  assign is_branch = (opcode == OP_B);
  assign is_ctrl   = (opcode == OP_JAL) | (opcode == OP_JALR) | (opcode == OP_B);
  assign is_mret   = (opcode == OP_CSR) & (func3 == F3_PRIV) & (instr[31:20] == MRET_IMM);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 3-stage RV32I stall/flush/forward/trap sequencer
// Purpose: decodes DE against a tracked copy of MW and drives stalls, flushes,
//          bubbles, PC select and forwarding; sequences data-memory waits with
//          a timeout fault, external-interrupt entry and mret.
// Ports:   clk, rst (async, active high); bus (pipe_hazard_ctrl_if.slave).
module pipe_hazard_ctrl
  import rv_pkg::*;
#(
  parameter bit LOAD_USE_STALL = 1'b1,
  parameter int MEM_TIMEOUT    = 16,
  parameter int CNT_W          = 8
)
(
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // cnt holds wait cycles already elapsed, so the current one is cnt+1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e      state;
  logic [CNT_W-1:0] cnt;

  logic       mw_valid, mw_we, mw_load, mw_store;
  logic [4:0] mw_rd;

  logic [4:0] de_rs1, de_rs2, de_rd;
  logic       de_uses_rs1, de_uses_rs2, de_writes_rd;
  logic       de_is_load, de_is_store, de_is_ctrl, de_is_branch, de_is_mret;

  de_reg_use_decode u_de_decode (
    .instr     (bus.instr_de),
    .rs1       (de_rs1),
    .rs2       (de_rs2),
    .rd        (de_rd),
    .uses_rs1  (de_uses_rs1),
    .uses_rs2  (de_uses_rs2),
    .writes_rd (de_writes_rd),
    .is_load   (de_is_load),
    .is_store  (de_is_store),
    .is_ctrl   (de_is_ctrl),
    .is_branch (de_is_branch),
    .is_mret   (de_is_mret)
  );

  logic hit_rs1, hit_rs2, mem_hold, load_use, irq_req, ctrl_taken, timeout;

  // mw_we is only set for rd != x0, so a hit never selects forwarding for x0.
  assign hit_rs1    = mw_valid & mw_we & de_uses_rs1 & (de_rs1 == mw_rd);
  assign hit_rs2    = mw_valid & mw_we & de_uses_rs2 & (de_rs2 == mw_rd);
  assign mem_hold   = mw_valid & (mw_load | mw_store) & ~bus.mem_ready;
  assign load_use   = mw_load & (hit_rs1 | hit_rs2);
  assign irq_req    = bus.ext_irq & bus.irq_en & bus.valid_de;
  assign ctrl_taken = de_is_ctrl & (~de_is_branch | bus.br_taken);
  assign timeout    = (cnt == CNT_LAST);

  logic    stall_if_c, stall_mw_c, flush_de_c, bubble_mw_c;
  logic    epc_we_c, irq_ack_c, mem_fault_c, run_normal;
  pc_sel_e pc_sel_c;

  always_comb begin
    stall_if_c  = 1'b0;
    stall_mw_c  = 1'b0;
    flush_de_c  = 1'b0;
    bubble_mw_c = 1'b0;
    epc_we_c    = 1'b0;
    irq_ack_c   = 1'b0;
    mem_fault_c = 1'b0;
    pc_sel_c    = PC_PLUS4;
    run_normal  = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (mem_hold) begin
            stall_if_c = 1'b1;
            stall_mw_c = 1'b1;
          end else if (irq_req) begin
            pc_sel_c    = PC_MTVEC;
            epc_we_c    = 1'b1;
            irq_ack_c   = 1'b1;
            flush_de_c  = 1'b1;
            bubble_mw_c = 1'b1;
          end else begin
            run_normal = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            // Access completed: DE proceeds this cycle, so its own
            // transfers and hazards still need handling.
            run_normal = 1'b1;
          end else if (timeout) begin
            // PC must be free to load mtvec; stall_mw stays up so the
            // faulting access never writes the regfile.
            mem_fault_c = 1'b1;
            pc_sel_c    = PC_MTVEC;
            flush_de_c  = 1'b1;
            bubble_mw_c = 1'b1;
            stall_mw_c  = 1'b1;
          end else begin
            stall_if_c = 1'b1;
            stall_mw_c = 1'b1;
          end
        end
        default: ;
      endcase
      if (run_normal && bus.valid_de) begin
        if (de_is_mret) begin
          pc_sel_c   = PC_MEPC;
          flush_de_c = 1'b1;
        end else if (ctrl_taken) begin
          pc_sel_c   = PC_TARGET;
          flush_de_c = 1'b1;
        end else if (LOAD_USE_STALL && load_use) begin
          stall_if_c  = 1'b1;
          bubble_mw_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      mw_valid <= 1'b0;
      mw_rd    <= '0;
      mw_we    <= 1'b0;
      mw_load  <= 1'b0;
      mw_store <= 1'b0;
    end else begin
      // A bubble overrides a hold, which also clears MW on an access fault.
      if (bubble_mw_c) begin
        mw_valid <= 1'b0;
        mw_rd    <= '0;
        mw_we    <= 1'b0;
        mw_load  <= 1'b0;
        mw_store <= 1'b0;
      end else if (!stall_mw_c) begin
        mw_valid <= bus.valid_de;
        mw_rd    <= de_rd;
        mw_we    <= de_writes_rd;
        mw_load  <= de_is_load;
        mw_store <= de_is_store;
      end
      case (state)
        RUN: begin
          if (mem_hold) begin
            state <= MEM_WAIT;
            cnt   <= CNT_ONE;
          end else if (irq_ack_c) begin
            state <= TRAP_HOLD;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            state <= RUN;
            cnt   <= '0;
          end else if (timeout) begin
            state <= TRAP_HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        TRAP_HOLD: state <= RUN;
        default:   state <= RUN;
      endcase
    end
  end

  assign bus.stall_if  = stall_if_c;
  assign bus.stall_mw  = stall_mw_c;
  assign bus.flush_de  = flush_de_c;
  assign bus.bubble_mw = bubble_mw_c;
  assign bus.pc_sel    = pc_sel_c;
  assign bus.fwd_a     = hit_rs1;
  assign bus.fwd_b     = hit_rs2;
  assign bus.epc_we    = epc_we_c;
  assign bus.irq_ack   = irq_ack_c;
  assign bus.mem_fault = mem_fault_c;
  assign bus.busy      = (state != RUN);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  import rv_pkg::*;

  localparam logic [31:0] ADD_X5   = 32'h002082B3; // add x5,x1,x2
  localparam logic [31:0] SUB_X6   = 32'h40528333; // sub x6,x5,x5
  localparam logic [31:0] ADD_X0   = 32'h00208033; // add x0,x1,x2
  localparam logic [31:0] SUB_X6_0 = 32'h40000333; // sub x6,x0,x0
  localparam logic [31:0] LW_X7    = 32'h0000A383; // lw x7,0(x1)
  localparam logic [31:0] ADD_X8   = 32'h00338433; // add x8,x7,x3
  localparam logic [31:0] SW_X2    = 32'h0020A023; // sw x2,0(x1)
  localparam logic [31:0] BEQ      = 32'h00208463; // beq x1,x2,8
  localparam logic [31:0] JAL_X1   = 32'h000000EF; // jal x1,0
  localparam logic [31:0] MRET     = 32'h30200073;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus();
  pipe_hazard_ctrl_if bus0();

  assign bus0.instr_de  = bus.instr_de;
  assign bus0.valid_de  = bus.valid_de;
  assign bus0.br_taken  = bus.br_taken;
  assign bus0.mem_ready = bus.mem_ready;
  assign bus0.ext_irq   = bus.ext_irq;
  assign bus0.irq_en    = bus.irq_en;

  pipe_hazard_ctrl #(.LOAD_USE_STALL(1'b1), .MEM_TIMEOUT(16), .CNT_W(8)) u_dut (
    .clk (clk), .rst (rst), .bus (bus.slave));

  pipe_hazard_ctrl #(.LOAD_USE_STALL(1'b0), .MEM_TIMEOUT(16), .CNT_W(8)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave));

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        valid, br, ready, irq, ien;
    logic [11:0] exp;
    bit          chk0;
    logic [2:0]  exp0;
  } vec_t;

  typedef struct {
    string       name;
    logic [11:0] exp;
    bit          chk0;
    logic [2:0]  exp0;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   total = 0;
  int   bad   = 0;

  // {pc_sel, stall_if, stall_mw, flush_de, bubble_mw, fwd_a, fwd_b, epc_we, irq_ack, mem_fault, busy}
  function automatic logic [11:0] o(input logic [1:0] pc, input bit sif, smw, fl, bub,
                                    fa, fb, epc, ack, flt, bsy);
    return {pc, sif, smw, fl, bub, fa, fb, epc, ack, flt, bsy};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic v, br, rdy, irq, ien);
    bus.instr_de  = instr;
    bus.valid_de  = v;
    bus.br_taken  = br;
    bus.mem_ready = rdy;
    bus.ext_irq   = irq;
    bus.irq_en    = ien;
  endtask

  task automatic expect_out(input string name, input logic [11:0] e, input bit c0,
                            input logic [2:0] e0);
    sb_t s;
    s.name = name;
    s.exp  = e;
    s.chk0 = c0;
    s.exp0 = e0;
    sbq.push_back(s);
  endtask

  task automatic check_out();
    sb_t s;
    logic [11:0] a;
    logic [2:0]  a0;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries, required 1");
    end else begin
      s = sbq.pop_front();
      a = {bus.pc_sel, bus.stall_if, bus.stall_mw, bus.flush_de, bus.bubble_mw, bus.fwd_a,
           bus.fwd_b, bus.epc_we, bus.irq_ack, bus.mem_fault, bus.busy};
      if (a !== s.exp) begin
        bad++;
        $display("FAIL %s: got %b required %b (pc_sel,sif,smw,flush,bubble,fa,fb,epc,ack,fault,busy)",
                 s.name, a, s.exp);
      end
      if (s.chk0) begin
        total++;
        a0 = {bus0.stall_if, bus0.bubble_mw, bus0.fwd_a};
        if (a0 !== s.exp0) begin
          bad++;
          $display("FAIL %s_no_lu_stall: got %b required %b (stall_if,bubble_mw,fwd_a)",
                   s.name, a0, s.exp0);
        end
      end
    end
  endtask

  task automatic step(input string name, input logic [31:0] instr, input logic v, br, rdy,
                      irq, ien, input logic [11:0] e, input bit c0 = 1'b0,
                      input logic [2:0] e0 = 3'b000);
    @(posedge clk);
    #1;
    drive(instr, v, br, rdy, irq, ien);
    expect_out(name, e, c0, e0);
    @(negedge clk);
    check_out();
  endtask

  task automatic add_vec(input string name, input logic [31:0] instr, input logic v, br, rdy,
                         irq, ien, input logic [11:0] e, input bit c0 = 1'b0,
                         input logic [2:0] e0 = 3'b000);
    vec_t r;
    r.name = name; r.instr = instr; r.valid = v; r.br = br; r.ready = rdy;
    r.irq = irq; r.ien = ien; r.exp = e; r.chk0 = c0; r.exp0 = e0;
    vecs.push_back(r);
  endtask

  logic [11:0] e0v;

  initial begin
    e0v = o(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Consecutive cycles after reset: name, instr, valid, br, ready, irq, irq_en, expected.
    add_vec("fwd_producer",  ADD_X5,   1, 0, 1, 0, 0, e0v);
    add_vec("fwd_both",      SUB_X6,   1, 0, 1, 0, 0, o(2'd0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    add_vec("x0_producer",   ADD_X0,   1, 0, 1, 0, 0, e0v);
    add_vec("x0_consumer",   SUB_X6_0, 1, 0, 1, 0, 0, e0v);
    add_vec("lw_issue",      LW_X7,    1, 0, 1, 0, 0, e0v);
    add_vec("load_use",      ADD_X8,   1, 0, 1, 0, 0, o(2'd0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0),
            1'b1, 3'b001);
    add_vec("load_use_go",   ADD_X8,   1, 0, 1, 0, 0, e0v);
    add_vec("sw_issue",      SW_X2,    1, 0, 1, 0, 0, e0v);
    add_vec("memw_1",        NOP,      1, 0, 0, 0, 0, o(2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add_vec("memw_2",        NOP,      1, 0, 0, 0, 0, o(2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    add_vec("memw_3",        NOP,      1, 0, 0, 0, 0, o(2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    add_vec("memw_ready",    NOP,      1, 0, 1, 0, 0, o(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add_vec("beq_taken",     BEQ,      1, 1, 1, 0, 0, o(2'd1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    add_vec("beq_not_taken", BEQ,      1, 0, 1, 0, 0, e0v);
    add_vec("irq_vs_jal",    JAL_X1,   1, 0, 1, 1, 1, o(2'd2, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0));
    add_vec("trap_hold",     JAL_X1,   1, 0, 1, 1, 1, o(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add_vec("irq_disabled",  NOP,      1, 0, 1, 1, 0, e0v);
    add_vec("mret",          MRET,     1, 0, 1, 0, 0, o(2'd3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    add_vec("jal_invalid",   JAL_X1,   0, 0, 1, 0, 0, e0v);
    add_vec("irq_invalid",   NOP,      0, 0, 1, 1, 1, e0v);

    // Reset holds every output low even with a taken branch and an interrupt pending.
    rst = 1'b1;
    drive(BEQ, 1, 1, 0, 1, 1);
    @(negedge clk);
    @(negedge clk);
    expect_out("reset", e0v, 1'b0, 3'b000);
    check_out();
    drive(NOP, 0, 0, 1, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].name, vecs[i].instr, vecs[i].valid, vecs[i].br, vecs[i].ready,
           vecs[i].irq, vecs[i].ien, vecs[i].exp, vecs[i].chk0, vecs[i].exp0);

    // Store with mem_ready low long enough to hit the 16-cycle timeout.
    step("to_sw", SW_X2, 1, 0, 1, 0, 0, e0v);
    for (int i = 1; i <= 16; i++) begin
      if (i < 16)
        step($sformatf("to_wait%0d", i), NOP, 1, 0, 0, 0, 0,
             o(2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, i > 1));
      else
        step("to_fault", NOP, 1, 0, 0, 0, 0, o(2'd2, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1));
    end
    step("to_hold", NOP, 1, 0, 0, 1, 1, o(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step("to_run",  NOP, 1, 0, 0, 0, 0, e0v);

    // Asynchronous reset in the middle of a memory wait.
    step("rw_sw", SW_X2, 1, 0, 1, 0, 0, e0v);
    step("rw_w1", NOP,   1, 0, 0, 0, 0, o(2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    step("rw_w2", BEQ,   1, 1, 0, 0, 0, o(2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    #2;
    rst = 1'b1;
    expect_out("rst_async", e0v, 1'b0, 3'b000);
    #1;
    check_out();
    @(negedge clk);
    drive(NOP, 0, 0, 1, 0, 0);
    rst = 1'b0;
    step("post_rst", NOP, 1, 0, 1, 0, 0, e0v);
    step("post_beq", BEQ, 1, 1, 1, 0, 0, o(2'd1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
